// File: rtl/datapath_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// datapath_ctrl_fsm
// Instruction-sequencing controller for the datapath. One 16-bit instruction
// is accepted per start handshake (s while in WAIT). It is latched into IR,
// decoded, and the datapath is then stepped through its read / execute /
// writeback stages by driving the datapath control inputs.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   s         start; sampled only in WAIT
//   in        instruction word, latched together with s
//   w         1 while in WAIT (ready for the next instruction)
//   illegal   sticky: last accepted instruction was unsupported
//   sximm8    sign-extended IR[7:0], feeds datapath_in
//   readnum   register-file read index
//   writenum  register-file write index
//   write     register-file write enable
//   vsel      1 = write sximm8, 0 = write C
//   loada     A register load
//   loadb     B register load
//   asel      1 = ALU A operand forced to 0
//   bsel      1 = ALU B operand from sximm8 (never used here)
//   shift     shifter control
//   ALUop     00 ADD, 01 SUB, 10 AND, 11 NOT-B
//   loadc     C register load
//   loads     status register load
// ---------------------------------------------------------------------------
module datapath_ctrl_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic        s,
   input  logic [15:0] in,
   output logic        w,
   output logic        illegal,
   output logic [15:0] sximm8,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic        loadc,
   output logic        loads
);

   typedef enum logic [2:0] {
      S_WAIT      = 3'd0,
      S_DECODE    = 3'd1,
      S_GET_A     = 3'd2,
      S_GET_B     = 3'd3,
      S_CALC      = 3'd4,
      S_WRITE_IMM = 3'd5,
      S_WRITE_REG = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      K_MOVI = 3'd0,
      K_MOVR = 3'd1,
      K_ADD  = 3'd2,
      K_CMP  = 3'd3,
      K_AND  = 3'd4,
      K_MVN  = 3'd5,
      K_ILL  = 3'd6
   } kind_t;

   state_t      state_r;
   logic [15:0] ir_r;
   logic        illegal_r;
   kind_t       kind_s;

   // Classify an instruction word by its opcode/op fields.
   function automatic kind_t decode_kind(input logic [15:0] ir);
      kind_t k;
      case ({ir[15:13], ir[12:11]})
         5'b110_10: k = K_MOVI;
         5'b110_00: k = K_MOVR;
         5'b101_00: k = K_ADD;
         5'b101_01: k = K_CMP;
         5'b101_10: k = K_AND;
         5'b101_11: k = K_MVN;
         default:   k = K_ILL;
      endcase
      return k;
   endfunction

   assign kind_s  = decode_kind(ir_r);
   assign sximm8  = {{8{ir_r[7]}}, ir_r[7:0]};
   assign illegal = illegal_r;

   // State, instruction register and sticky illegal flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_WAIT;
         ir_r      <= 16'h0000;
         illegal_r <= 1'b0;
      end else begin
         case (state_r)
            S_WAIT: begin
               if (s) begin
                  ir_r      <= in;
                  illegal_r <= 1'b0;
                  state_r   <= S_DECODE;
               end else begin
                  state_r   <= S_WAIT;
               end
            end
            S_DECODE: begin
               case (kind_s)
                  K_MOVI:        state_r <= S_WRITE_IMM;
                  K_MOVR, K_MVN: state_r <= S_GET_B;
                  K_ADD, K_CMP,
                  K_AND:         state_r <= S_GET_A;
                  default: begin
                     // Unsupported encoding: drop it and flag it.
                     state_r   <= S_WAIT;
                     illegal_r <= 1'b1;
                  end
               endcase
            end
            S_GET_A: state_r <= S_GET_B;
            S_GET_B: state_r <= S_CALC;
            S_CALC: begin
               // CMP only updates status, so it has no writeback stage.
               if (kind_s == K_CMP) begin
                  state_r <= S_WAIT;
               end else begin
                  state_r <= S_WRITE_REG;
               end
            end
            S_WRITE_IMM: state_r <= S_WAIT;
            S_WRITE_REG: state_r <= S_WAIT;
            default:     state_r <= S_WAIT;
         endcase
      end
   end

   // Moore control outputs decoded from state and IR fields.
   always_comb begin
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      write    = 1'b0;
      vsel     = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      shift    = 2'b00;
      ALUop    = 2'b00;
      loadc    = 1'b0;
      loads    = 1'b0;
      case (state_r)
         S_WAIT: w = 1'b1;
         S_DECODE: begin
            w = 1'b0;
         end
         S_GET_A: begin
            readnum = ir_r[10:8];
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = ir_r[2:0];
            loadb   = 1'b1;
         end
         S_CALC: begin
            shift = ir_r[4:3];
            // MOV reg and MVN are single-operand: zero the A side.
            if ((kind_s == K_MOVR) || (kind_s == K_MVN)) begin
               asel = 1'b1;
            end else begin
               asel = 1'b0;
            end
            case (kind_s)
               K_CMP:   ALUop = 2'b01;
               K_AND:   ALUop = 2'b10;
               K_MVN:   ALUop = 2'b11;
               default: ALUop = 2'b00;
            endcase
            if (kind_s == K_CMP) begin
               loads = 1'b1;
            end else begin
               loadc = 1'b1;
            end
         end
         S_WRITE_IMM: begin
            writenum = ir_r[10:8];
            vsel     = 1'b1;
            write    = 1'b1;
         end
         S_WRITE_REG: begin
            writenum = ir_r[7:5];
            vsel     = 1'b0;
            write    = 1'b1;
         end
         default: begin
            w = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_datapath_ctrl_fsm.sv
module tb_datapath_ctrl_fsm;

   logic        clk;
   logic        reset;
   logic        s;
   logic [15:0] in;
   logic        w;
   logic        illegal;
   logic [15:0] sximm8;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        vsel;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic        loadc;
   logic        loads;

   int n_checks = 0;
   int n_fails  = 0;

   logic [35:0] exp_q[$];

   datapath_ctrl_fsm dut (
      .clk(clk), .reset(reset), .s(s), .in(in),
      .w(w), .illegal(illegal), .sximm8(sximm8),
      .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
      .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Pack an expected output set into one vector.
   function automatic logic [35:0] mk(
      input logic ew, input logic eill, input logic [15:0] esx,
      input logic [2:0] ern, input logic [2:0] ewn, input logic ewr, input logic evs,
      input logic ela, input logic elb, input logic eas, input logic ebs,
      input logic [1:0] esh, input logic [1:0] eop, input logic elc, input logic els);
      return {ew, eill, esx, ern, ewn, ewr, evs, ela, elb, eas, ebs, esh, eop, elc, els};
   endfunction

   function automatic logic [35:0] dut_vec();
      return {w, illegal, sximm8, readnum, writenum, write, vsel,
              loada, loadb, asel, bsel, shift, ALUop, loadc, loads};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Push the expected per-cycle outputs from DECODE back to WAIT; return latency.
   task automatic push_model(input logic [15:0] instr, output int lat);
      logic [4:0]  key;
      logic [15:0] sx;
      logic [2:0]  rn, rd, rm;
      logic [1:0]  sh;
      logic        movr, mvn, cmp, legal_alu;
      logic [1:0]  op_exp;
      key = {instr[15:13], instr[12:11]};
      sx  = {{8{instr[7]}}, instr[7:0]};
      rn  = instr[10:8];
      rd  = instr[7:5];
      sh  = instr[4:3];
      rm  = instr[2:0];
      movr = (key == 5'b110_00);
      mvn  = (key == 5'b101_11);
      cmp  = (key == 5'b101_01);
      legal_alu = movr || (key[4:2] == 3'b101);
      op_exp = movr ? 2'b00 : key[1:0];
      exp_q.push_back(mk(1'b0, 1'b0, sx, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
      if (key == 5'b110_10) begin
         exp_q.push_back(mk(1'b0, 1'b0, sx, 3'd0, rn, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
         exp_q.push_back(mk(1'b1, 1'b0, sx, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
         lat = 3;
      end else if (legal_alu) begin
         lat = 4;
         if (!(movr || mvn)) begin
            exp_q.push_back(mk(1'b0, 1'b0, sx, rn, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
            lat++;
         end
         exp_q.push_back(mk(1'b0, 1'b0, sx, rm, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
         exp_q.push_back(mk(1'b0, 1'b0, sx, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, movr || mvn, 1'b0, sh, op_exp, !cmp, cmp));
         if (!cmp) begin
            exp_q.push_back(mk(1'b0, 1'b0, sx, 3'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
            lat++;
         end
         exp_q.push_back(mk(1'b1, 1'b0, sx, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
      end else begin
         exp_q.push_back(mk(1'b1, 1'b1, sx, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0));
         lat = 2;
      end
   endtask

   // Issue one instruction from WAIT and score every cycle until it returns.
   task automatic run_instr(input string tag, input logic [15:0] instr, input bit noisy, input int lat_spec);
      int lat_model;
      int edges;
      int w_edge;
      logic [35:0] e;
      in = instr;
      s  = 1'b1;
      step();
      push_model(instr, lat_model);
      check_val({tag, "_model_lat"}, 64'(lat_model), 64'(lat_spec));
      edges  = 1;
      w_edge = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_val({tag, "_cyc", $sformatf("%0d", edges)}, 64'(dut_vec()), 64'(e));
         if ((w === 1'b1) && (w_edge < 0)) w_edge = edges;
         if (exp_q.size() > 0) begin
            if (noisy) begin
               s  = 1'($urandom_range(0, 1));
               in = 16'($urandom);
            end else begin
               s  = 1'b0;
            end
            step();
            edges++;
         end
      end
      s = 1'b0;
      check_val({tag, "_latency"}, 64'(w_edge), 64'(lat_spec));
   endtask

   initial begin
      reset = 1'b1;
      s     = 1'b0;
      in    = 16'h0000;
      step();
      check_val("reset_state", 64'(dut_vec()),
                64'(mk(1'b1, 1'b0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0)));
      reset = 1'b0;
      step();
      check_val("idle_w", 64'(w), 64'(1'b1));

      run_instr("movi_pos", 16'hD007, 1'b0, 3);
      run_instr("movi_neg", 16'hD1FE, 1'b0, 3);
      run_instr("add",      16'hA148, 1'b1, 6);
      run_instr("cmp",      16'hA900, 1'b1, 5);
      run_instr("illegal",  16'hE000, 1'b0, 2);
      check_val("illegal_sticky", 64'(illegal), 64'(1'b1));
      // Back-to-back acceptance: the next instruction clears illegal.
      run_instr("and",      16'hB2F1, 1'b0, 6);
      run_instr("mvn",      16'hB8B3, 1'b1, 5);
      run_instr("movr",     16'hC0E5, 1'b0, 5);
      run_instr("ill_op",   16'hC800, 1'b0, 2);
      run_instr("ill_opc",  16'h0123, 1'b0, 2);
      run_instr("movi_b2b", 16'hD580, 1'b0, 3);

      // Reset during GET_B abandons the ADD with no write.
      in = 16'hA148;
      s  = 1'b1;
      step();
      s = 1'b0;
      check_val("rst_mid_decode_wr", 64'(write), 64'(1'b0));
      step();
      check_val("rst_mid_geta", 64'({readnum, loada, write}), 64'({3'd1, 1'b1, 1'b0}));
      step();
      check_val("rst_mid_getb", 64'({readnum, loadb, write}), 64'({3'd0, 1'b1, 1'b0}));
      reset = 1'b1;
      s     = 1'b1;
      step();
      reset = 1'b0;
      s     = 1'b0;
      check_val("rst_mid_wait", 64'(dut_vec()),
                64'(mk(1'b1, 1'b0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0)));
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("rst_mid_idle", 64'({w, write}), 64'({1'b1, 1'b0}));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
